// File: rtl/pc_sequencer_4.sv
// pc_sequencer_4: 4-bit program-counter register and control FSM.
// The PC feeds an external combinational incrementer and captures its sum,
// or overrides it with a branch target, stall hold or halt. Carry-outs seen
// on advances are counted as address-space wrap-arounds (saturating).
// Optional feature macro: PC_WRAP_TRAP_EN -- when defined, a wrapping advance
// also raises trap and moves the FSM to HALT; when undefined, trap is tied to 0.
module pc_sequencer_4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stall,
  input  logic       skip,
  input  logic       branch_en,
  input  logic [3:0] branch_tgt,
  input  logic       halt_req,
  input  logic [3:0] inc_sum,
  input  logic       inc_cout,
  output logic [3:0] pc,
  output logic       inc_cin,
  output logic       pc_valid,
  output logic [1:0] state,
  output logic [3:0] wrap_cnt,
  output logic       trap
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    STALL = 2'b10,
    HALT  = 2'b11
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] pc_q, pc_d;
  logic [3:0] wrap_q, wrap_d;
  logic       trap_q, trap_d;

  // Incrementer request and fetch qualifier, decoded from registered state.
  assign pc_valid = (state_q == RUN);
  assign inc_cin  = skip & (state_q == RUN);
  assign pc       = pc_q;
  assign state    = state_q;
  assign wrap_cnt = wrap_q;

  // Next-state, next-PC and wrap bookkeeping.
  always_comb begin
    // NOTE: every target gets a hold default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    pc_d    = pc_q;
    wrap_d  = wrap_q;
    trap_d  = trap_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        if (halt_req) begin
          state_d = HALT;
        end else if (branch_en) begin
          pc_d = branch_tgt;
        end else if (stall) begin
          state_d = STALL;
        end else begin
          pc_d = inc_sum;
          if (inc_cout) begin
            if (wrap_q != 4'hF) wrap_d = wrap_q + 4'd1;
`ifdef PC_WRAP_TRAP_EN
            trap_d  = 1'b1;
            state_d = HALT;
`endif
          end
        end
      end
      STALL: begin
        if (halt_req)    state_d = HALT;
        else if (!stall) state_d = RUN;
      end
      HALT: begin
        if (start) begin
          state_d = RUN;
          pc_d    = 4'h0;
          wrap_d  = 4'h0;
          trap_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, PC and wrap counter registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= 4'h0;
      wrap_q  <= 4'h0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wrap_q  <= wrap_d;
      trap_q  <= trap_d;
    end
  end

`ifdef PC_WRAP_TRAP_EN
  assign trap = trap_q;
`else
  // Without the trap feature the flag is permanently clear.
  assign trap = 1'b0;
  logic unused_trap;
  assign unused_trap = trap_q;
`endif

endmodule

// File: tb/tb_pc_sequencer_4.sv
// Self-checking bench for pc_sequencer_4: table-driven single-cycle vectors
// plus hand sequences for async reset, full wrap, and wrap-count saturation.
// The external incrementer is modelled here as plain combinational logic.
module tb_pc_sequencer_4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stall, skip, branch_en, halt_req;
  logic [3:0] branch_tgt;
  logic [3:0] inc_sum;
  logic       inc_cout;
  logic [3:0] pc;
  logic       inc_cin, pc_valid;
  logic [1:0] state;
  logic [3:0] wrap_cnt;
  logic       trap;

  int tests = 0;
  int fails = 0;

  localparam logic [1:0] S_IDLE = 2'b00, S_RUN = 2'b01, S_STALL = 2'b10, S_HALT = 2'b11;

  pc_sequencer_4 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .skip(skip),
    .branch_en(branch_en), .branch_tgt(branch_tgt), .halt_req(halt_req),
    .inc_sum(inc_sum), .inc_cout(inc_cout), .pc(pc), .inc_cin(inc_cin),
    .pc_valid(pc_valid), .state(state), .wrap_cnt(wrap_cnt), .trap(trap)
  );

  always #5 clk = ~clk;

  // External incrementer: pc + 1 + cin.
  always_comb {inc_cout, inc_sum} = {1'b0, pc} + 5'd1 + {4'd0, inc_cin};

  typedef struct {
    logic       start, stall, skip, branch_en, halt_req;
    logic [3:0] tgt;
    logic       exp_cin;   // inc_cin before the edge
    logic [3:0] exp_pc;    // after the edge
    logic [1:0] exp_state;
    logic       exp_valid;
    logic [3:0] exp_wrap;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic s, input logic st, input logic sk,
                       input logic br, input logic [3:0] tg, input logic h);
    start = s; stall = st; skip = sk; branch_en = br; branch_tgt = tg; halt_req = h;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 4'h0, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 4'h0, 0);

    // start stl skp br hlt tgt  cin  pc    state    vld wrap
    vecs[0]  = '{1, 0, 0, 0, 0, 4'h0, 0, 4'h0, S_RUN,   1, 4'h0}; // start
    vecs[1]  = '{1, 0, 0, 1, 0, 4'h3, 0, 4'h3, S_RUN,   1, 4'h0}; // branch, start ignored
    vecs[2]  = '{0, 0, 1, 0, 0, 4'h0, 1, 4'h5, S_RUN,   1, 4'h0}; // skip 3->5
    vecs[3]  = '{0, 0, 1, 0, 0, 4'h0, 1, 4'h7, S_RUN,   1, 4'h0}; // skip 5->7
    vecs[4]  = '{0, 0, 0, 1, 0, 4'h4, 0, 4'h4, S_RUN,   1, 4'h0}; // branch to 4
    vecs[5]  = '{0, 1, 0, 0, 0, 4'h0, 0, 4'h4, S_STALL, 0, 4'h0}; // stall 1
    vecs[6]  = '{0, 1, 1, 1, 0, 4'h9, 0, 4'h4, S_STALL, 0, 4'h0}; // stall 2, branch/skip ignored
    vecs[7]  = '{0, 1, 0, 0, 0, 4'h0, 0, 4'h4, S_STALL, 0, 4'h0}; // stall 3
    vecs[8]  = '{0, 0, 0, 0, 0, 4'h0, 0, 4'h4, S_RUN,   1, 4'h0}; // bubble
    vecs[9]  = '{0, 0, 0, 0, 0, 4'h0, 0, 4'h5, S_RUN,   1, 4'h0}; // advance
    vecs[10] = '{0, 0, 0, 1, 0, 4'h2, 0, 4'h2, S_RUN,   1, 4'h0}; // branch to 2
    vecs[11] = '{0, 0, 0, 1, 1, 4'hA, 0, 4'h2, S_HALT,  0, 4'h0}; // halt beats branch
    vecs[12] = '{1, 0, 0, 0, 0, 4'h0, 0, 4'h0, S_RUN,   1, 4'h0}; // restart from HALT

    tick();
    rst_n = 1'b1;
    #1;
    check("reset_pc", {4'h0, pc}, 8'h00);
    check("reset_state", {6'h0, state}, {6'h0, S_IDLE});
    check("reset_valid", {7'h0, pc_valid}, 8'h00);
    check("reset_cin", {7'h0, inc_cin}, 8'h00);
    check("reset_wrap", {4'h0, wrap_cnt}, 8'h00);
    check("reset_trap", {7'h0, trap}, 8'h00);

    // IDLE ignores everything but start.
    drive(0, 0, 1, 1, 4'h7, 1);
    tick();
    check("idle_hold_state", {6'h0, state}, {6'h0, S_IDLE});
    check("idle_hold_pc", {4'h0, pc}, 8'h00);

    // Table-driven vectors.
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].start, vecs[i].stall, vecs[i].skip, vecs[i].branch_en, vecs[i].tgt, vecs[i].halt_req);
      #1;
      check($sformatf("v%0d_cin", i), {7'h0, inc_cin}, {7'h0, vecs[i].exp_cin});
      tick();
      check($sformatf("v%0d_pc", i), {4'h0, pc}, {4'h0, vecs[i].exp_pc});
      check($sformatf("v%0d_state", i), {6'h0, state}, {6'h0, vecs[i].exp_state});
      check($sformatf("v%0d_valid", i), {7'h0, pc_valid}, {7'h0, vecs[i].exp_valid});
      check($sformatf("v%0d_wrap", i), {4'h0, wrap_cnt}, {4'h0, vecs[i].exp_wrap});
    end

    // Asynchronous reset mid-RUN at pc=6, with a nonzero wrap count.
    drive(0, 0, 0, 1, 4'hF, 0);
    tick();
    drive(0, 0, 0, 0, 4'h0, 0);
    tick();                      // F -> 0, one wrap (macro on: HALT)
    drive(1, 0, 0, 0, 4'h0, 0);  // restart if halted; ignored in RUN
    tick();
    drive(0, 0, 0, 1, 4'h6, 0);
    tick();
    check("pre_rst_pc", {4'h0, pc}, 8'h06);
    drive(0, 0, 0, 0, 4'h0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_pc", {4'h0, pc}, 8'h00);
    check("async_rst_state", {6'h0, state}, {6'h0, S_IDLE});
    check("async_rst_valid", {7'h0, pc_valid}, 8'h00);
`ifndef PC_WRAP_TRAP_EN
    check("async_rst_wrap", {4'h0, wrap_cnt}, 8'h00);
`else
    check("async_rst_wrap", {4'h0, wrap_cnt}, 8'h00);
    check("async_rst_trap", {7'h0, trap}, 8'h00);
`endif
    #1;
    rst_n = 1'b1;
    tick();

    // start, then 16 plain advances: 1..F, 0.
    drive(1, 0, 0, 0, 4'h0, 0);
    tick();
    drive(0, 0, 0, 0, 4'h0, 0);
    for (int i = 1; i <= 16; i++) begin
      tick();
      check($sformatf("adv%0d_pc", i), {4'h0, pc}, 8'(i % 16));
    end
    check("full_wrap_cnt", {4'h0, wrap_cnt}, 8'h01);
`ifndef PC_WRAP_TRAP_EN
    check("full_wrap_state", {6'h0, state}, {6'h0, S_RUN});
    check("full_wrap_trap", {7'h0, trap}, 8'h00);

    // 20 forced wraps: branch to F, then advance; count saturates at F.
    for (int i = 1; i <= 20; i++) begin
      drive(0, 0, 0, 1, 4'hF, 0);
      tick();
      drive(0, 0, 0, 0, 4'h0, 0);
      tick();
      check($sformatf("sat%0d_wrap", i), {4'h0, wrap_cnt}, 8'((i + 1 > 15) ? 15 : i + 1));
    end
    check("sat_state", {6'h0, state}, {6'h0, S_RUN});

    // Skip across the top: F + 2 -> 1, one wrap (already saturated, stays F).
    drive(0, 0, 0, 1, 4'hF, 0);
    tick();
    drive(0, 0, 1, 0, 4'h0, 0);
    tick();
    check("skip_wrap_pc", {4'h0, pc}, 8'h01);
    check("skip_wrap_cnt", {4'h0, wrap_cnt}, 8'h0F);

    // Halt and restart clears the count.
    drive(0, 0, 0, 0, 4'h0, 1);
    tick();
    check("halt_state", {6'h0, state}, {6'h0, S_HALT});
    drive(1, 0, 0, 0, 4'h0, 0);
    tick();
    check("restart_pc", {4'h0, pc}, 8'h00);
    check("restart_wrap", {4'h0, wrap_cnt}, 8'h00);
    check("restart_state", {6'h0, state}, {6'h0, S_RUN});
`else
    check("trap_state", {6'h0, state}, {6'h0, S_HALT});
    check("trap_flag", {7'h0, trap}, 8'h01);

    // Restart clears trap and count; a branch to F does not trap.
    drive(1, 0, 0, 0, 4'h0, 0);
    tick();
    check("restart_trap", {7'h0, trap}, 8'h00);
    check("restart_wrap", {4'h0, wrap_cnt}, 8'h00);
    drive(0, 0, 0, 1, 4'hF, 0);
    tick();
    check("branch_no_trap", {6'h0, state}, {6'h0, S_RUN});
    drive(0, 0, 1, 0, 4'h0, 0);
    tick();
    check("skip_trap_pc", {4'h0, pc}, 8'h01);
    check("skip_trap_state", {6'h0, state}, {6'h0, S_HALT});
    check("skip_trap_wrap", {4'h0, wrap_cnt}, 8'h01);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_sequencer_4.md
# pc_sequencer_4

4-bit program-counter register and control FSM that drives the 4-bit incrementer in the datapath and registers its result. Each cycle it presents the current PC and a carry-in (0 for +1, 1 for +2 skip) to the incrementer. It then either captures the sum or overrides it with a branch target, stall hold or halt. It also counts address-space wrap-arounds reported on the incrementer carry-out.

## Interface
Parameters:
- none; width fixed at 4 bits to match the incrementer.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  leave IDLE/HALT and begin sequencing.
- stall  input  1  hold PC while high.
- skip  input  1  request PC+2 instead of PC+1 this cycle.
- branch_en  input  1  load branch_tgt this cycle.
- branch_tgt  input  4  branch destination.
- halt_req  input  1  stop sequencing.
- inc_sum  input  4  incrementer sum output.
- inc_cout  input  1  incrementer carry output.
- pc  output  4  current PC; drives incrementer operand.
- inc_cin  output  1  incrementer carry-in.
- pc_valid  output  1  PC is a live fetch address.
- state  output  2  FSM state encoding.
- wrap_cnt  output  4  saturating count of wrap-arounds.
- trap  output  1  wrap trap flag (see Configuration).

## Operation
- States: IDLE=2'b00, RUN=2'b01, STALL=2'b10, HALT=2'b11.
- Reset (rst_n=0, any time, asynchronous): pc=0, state=IDLE, wrap_cnt=0, trap=0. Combinational outputs follow: pc_valid=0, inc_cin=0. Mid-operation reset abandons the current state immediately.
- pc_valid = (state==RUN). inc_cin = skip & (state==RUN). Both are combinational from registered state.
- IDLE: start=1 -> RUN, pc unchanged (0 after reset). All other inputs ignored.
- RUN, priority high to low:
  - halt_req -> HALT, pc held.
  - branch_en -> pc<=branch_tgt, stay RUN, wrap_cnt unchanged.
  - stall -> STALL, pc held.
  - otherwise advance: pc<=inc_sum. If inc_cout=1, wrap_cnt<=wrap_cnt+1, saturating at 4'hF.
- start is ignored in RUN.
- STALL, priority high to low:
  - halt_req -> HALT.
  - stall=0 -> RUN, pc held; advance resumes the following cycle.
  - branch_en and skip are ignored.
- HALT: start=1 -> RUN with pc<=0, wrap_cnt<=0, trap<=0. Otherwise hold everything.
- Arithmetic is performed solely by the external incrementer. The block never adds internally.
- Wrap with skip: pc=4'hF, skip=1 -> inc_sum=4'h1, inc_cout=1. One wrap is counted.

## Timing
- Incrementer is combinational. The path pc -> inc_sum/inc_cout -> pc register closes in one cycle.
- Any input sampled at edge N takes effect on pc/state at edge N; it is visible after that edge.
- Advance latency: one cycle per PC step. Back-to-back advances give a new PC every cycle.
- Stall exit costs one bubble cycle: stall falls -> RUN with pc_valid=1 on the same pc -> advance on the next edge.
- start in IDLE: pc_valid rises one cycle after start is sampled.

## Configuration
- PC_WRAP_TRAP_EN defined:
  - An advance with inc_cout=1 still loads pc<=inc_sum and still increments wrap_cnt.
  - It also sets trap<=1 and moves to HALT.
  - Branches never trap.
- PC_WRAP_TRAP_EN undefined:
  - Wraps are silent; state stays RUN.
  - trap is constant 0.

## Test plan
- Reset mid-RUN at pc=4'h6 -> pc=0, state=IDLE, pc_valid=0, wrap_cnt=0 immediately, without a clock edge.
- start, then 16 plain advances from pc=0 -> pc sequence 1..F,0.
  - Macro off: wrap_cnt=1, state=RUN.
  - Macro on: trap=1, state=HALT, pc=0.
- RUN at pc=4'h3 with skip=1 for 2 cycles -> pc=5 then 7; inc_cin=1 during those cycles.
- pc=4'h4 with stall=1 for 3 cycles, then stall=0 -> pc holds 4 for the stall plus one bubble cycle, then becomes 5. A branch_en during the stall is ignored.
- Same cycle halt_req=1, branch_en=1, branch_tgt=4'hA at pc=2 -> HALT with pc=2.
  - Then start -> RUN, pc=0, wrap_cnt=0.
- Macro off, 20 forced wraps (branch to F, then advance, repeated) -> wrap_cnt saturates at 4'hF.
